// File: rtl/sica_est_serializer.sv
// sica_est_serializer: streams the flat s_est frame as channel-major words with
// valid/ready handshake, channel/sample tags and a last flag.
module sica_est_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int DIM        = 5,
   parameter int SAMPLES    = 1024,
   parameter int LOGM       = 10,
   parameter int CH_W       = 3
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [DATA_WIDTH*DIM*SAMPLES-1:0]     s_est,
   input  logic                                  sica_complete,
   output logic signed [DATA_WIDTH-1:0]          serial_s_out,
   output logic                                  serial_s_valid,
   input  logic                                  serial_s_ready,
   output logic                                  serial_s_last,
   output logic [CH_W-1:0]                       chan_idx,
   output logic [LOGM-1:0]                       sample_idx,
   output logic                                  busy,
   output logic                                  frame_done
);
   localparam int TOTAL = DIM * SAMPLES;
   localparam int KW    = LOGM + CH_W;
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   state_t state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic complete_q, valid_q, valid_d, last_q, last_d, done_q, done_d;
   logic start_edge, fin, load;
   assign start_edge = sica_complete & ~complete_q;
   assign fin        = k_q == KW'(TOTAL - 1);
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: if (start_edge) begin
            state_d = STREAM;
            k_d     = '0;
            valid_d = 1'b1;
            load    = 1'b1;
         end
         STREAM: if (serial_s_ready) begin
            if (fin) begin
               state_d = DONE;
               k_d     = '0;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               k_d  = k_q + 1'b1;
               load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      last_d = valid_d && (k_d == KW'(TOTAL - 1));
      // the word register is only refreshed on an advance, so a stall holds it
      out_d  = load ? s_est[32'(k_d) * DATA_WIDTH +: DATA_WIDTH] : (valid_d ? out_q : '0);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         out_q      <= '0;
         complete_q <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         out_q      <= out_d;
         complete_q <= sica_complete;
         valid_q    <= valid_d;
         last_q     <= last_d;
         done_q     <= done_d;
      end
   end
   assign serial_s_out   = out_q;
   assign serial_s_valid = valid_q;
   assign serial_s_last  = last_q;
   assign busy           = valid_q;
   assign frame_done     = done_q;
   assign chan_idx       = k_q[KW-1:LOGM];
   assign sample_idx     = k_q[LOGM-1:0];
endmodule

// File: tb/tb_sica_est_serializer.sv
// tb_sica_est_serializer: randomized and directed frames checked against a
// position-based reference of the serial stream.
module tb_sica_est_serializer;
   localparam int DW = 32, DIM = 2, SAMPLES = 4, LOGM = 2, CH_W = 1;
   localparam int TOTAL = DIM * SAMPLES;
   logic clk = 1'b0, reset = 1'b1, sica_complete = 1'b0, serial_s_ready = 1'b1;
   logic [DW*TOTAL-1:0] s_est;
   logic signed [DW-1:0] serial_s_out;
   logic serial_s_valid, serial_s_last, busy, frame_done;
   logic [CH_W-1:0] chan_idx;
   logic [LOGM-1:0] sample_idx;
   logic [DW-1:0] words [TOTAL];
   int n_checks = 0, n_fail = 0;
   int m_active = 0, m_n = 0, m_done = 0, m_prev_c = 0;
   int acc = 0, dones = 0, busy_cyc = 0;
   always #5 clk = ~clk;
   always_comb for (int i = 0; i < TOTAL; i++) s_est[i*DW +: DW] = words[i];
   sica_est_serializer #(.DATA_WIDTH(DW), .DIM(DIM), .SAMPLES(SAMPLES), .LOGM(LOGM), .CH_W(CH_W)) dut (
      .clk(clk), .reset(reset), .s_est(s_est), .sica_complete(sica_complete),
      .serial_s_out(serial_s_out), .serial_s_valid(serial_s_valid), .serial_s_ready(serial_s_ready),
      .serial_s_last(serial_s_last), .chan_idx(chan_idx), .sample_idx(sample_idx),
      .busy(busy), .frame_done(frame_done));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask
   // compare against the reference, advance the reference by one clock, then step
   task automatic cycle();
      check("valid", 32'(serial_s_valid), 32'(m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("last", 32'(serial_s_last), 32'(m_active != 0 && m_n == TOTAL - 1));
      if (m_active != 0) begin
         check("data", serial_s_out, words[m_n]);
         check("chan", 32'(chan_idx), 32'(m_n / SAMPLES));
         check("sample", 32'(sample_idx), 32'(m_n % SAMPLES));
      end else if (m_done == 0) begin
         check("idle_data", serial_s_out, 32'd0);
         check("idle_tags", {30'd0, chan_idx, sample_idx[0]}, 32'd0);
      end
      acc      += int'(serial_s_valid && serial_s_ready);
      dones    += int'(frame_done);
      busy_cyc += int'(busy);
      if (reset) begin
         m_active = 0; m_n = 0; m_done = 0; m_prev_c = 0;
      end else begin
         int nd;
         nd = int'(m_active != 0 && serial_s_ready && m_n == TOTAL - 1);
         if (m_active != 0 && serial_s_ready) begin
            if (m_n == TOTAL - 1) m_active = 0; else m_n++;
         end else if (m_active == 0 && m_done == 0 && sica_complete && m_prev_c == 0) begin
            m_active = 1; m_n = 0;
         end
         m_done   = nd;
         m_prev_c = int'(sica_complete);
      end
      @(posedge clk); #1;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask
   task automatic clear_counts();
      acc = 0; dones = 0; busy_cyc = 0;
   endtask
   initial begin
      int held;
      for (int i = 0; i < TOTAL; i++) words[i] = 100 + i;
      @(posedge clk); #1;
      run(2);
      reset = 1'b0;
      run(4);
      // full frame, ready tied high
      clear_counts();
      sica_complete = 1'b1;
      run(12);
      check("frame1_words", acc, 8);
      check("frame1_done", dones, 1);
      check("frame1_busy", busy_cyc, 8);
      // backpressure on words 2 and 5
      sica_complete = 1'b0;
      run(2);
      clear_counts();
      sica_complete = 1'b1;
      held = 0;
      for (int c = 0; c < 20; c++) begin
         if (m_active != 0 && (m_n == 2 || m_n == 5) && held < 3) begin
            serial_s_ready = 1'b0; held++;
         end else begin
            serial_s_ready = 1'b1;
            if (m_active != 0) held = 0;
         end
         cycle();
      end
      serial_s_ready = 1'b1;
      check("bp_words", acc, 8);
      check("bp_len", busy_cyc, 14);
      check("bp_done", dones, 1);
      // retrigger attempts while streaming and while held high
      sica_complete = 1'b0;
      run(2);
      clear_counts();
      sica_complete = 1'b1;
      run(4);
      sica_complete = 1'b0;
      run(1);
      sica_complete = 1'b1;
      run(35);
      check("hold_words", acc, 8);
      check("hold_done", dones, 1);
      // fresh edge gives a second frame, now with random data and random ready
      for (int i = 0; i < TOTAL; i++) words[i] = $urandom;
      sica_complete = 1'b0;
      run(1);
      clear_counts();
      sica_complete = 1'b1;
      for (int c = 0; c < 40; c++) begin
         serial_s_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      serial_s_ready = 1'b1;
      run(10);
      check("rand_words", acc, 8);
      check("rand_done", dones, 1);
      // reset after word 3 is accepted, sica_complete stays high
      for (int i = 0; i < TOTAL; i++) words[i] = 100 + i;
      sica_complete = 1'b0;
      run(1);
      clear_counts();
      sica_complete = 1'b1;
      for (int c = 0; c < 20 && !(m_active != 0 && m_n == 4); c++) cycle();
      check("pre_reset_pos", m_n, 4);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_valid", 32'(serial_s_valid), 32'd0);
      check("rst_no_done", dones, 0);
      clear_counts();
      run(12);
      check("restart_words", acc, 8);
      check("restart_done", dones, 1);
      // a few more random frames
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < TOTAL; i++) words[i] = $urandom;
         sica_complete = 1'b0;
         run(1 + f);
         clear_counts();
         sica_complete = 1'b1;
         for (int c = 0; c < 30; c++) begin
            serial_s_ready = ($urandom_range(0, 3) != 0);
            cycle();
         end
         serial_s_ready = 1'b1;
         run(10);
         check("rf_words", acc, 8);
         check("rf_done", dones, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sica_est_serializer.md
Name: sica_est_serializer

Overview:
- Output-side counterpart of the serial z loader: converts the flat `s_est` bus from `sica_top` into a serial word stream.
- The frame starts when `sica_complete` rises.
- Word order is channel-major, the same order in which `serial_z_in` is loaded: channel 0 samples 0..SAMPLES-1, then channel 1, and so on.
- Streams one word per cycle with valid/ready backpressure, and tags each word with channel index, sample index and a last flag.

Parameters:
- DATA_WIDTH, 32, width of one estimated-source word (signed).
- DIM, 5, number of channels/sources.
- SAMPLES, 1024, samples per channel; must equal 2**LOGM.
- LOGM, 10, sample index width.
- CH_W, 3, channel index width; must be at least clog2(DIM), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_est  in  DATA_WIDTH*DIM*SAMPLES  flat estimate bus. Word k = s_est[k*DATA_WIDTH +: DATA_WIDTH]. Source holds it stable while busy=1.
- sica_complete  in  1  frame-ready level from sica_top; a rising edge starts a frame.
- serial_s_out  out  DATA_WIDTH  current word (signed).
- serial_s_valid  out  1  serial_s_out and its tags are valid.
- serial_s_ready  in  1  downstream accepts the word when valid&ready.
- serial_s_last  out  1  high with the final word (k = DIM*SAMPLES-1).
- chan_idx  out  CH_W  channel of the current word, = k / SAMPLES.
- sample_idx  out  LOGM  sample of the current word, = k mod SAMPLES.
- busy  out  1  high from the frame start until the final transfer completes.
- frame_done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Word counter k has width LOGM+CH_W. Localparam TOTAL = DIM*SAMPLES.
- Edge detect: start_edge = sica_complete & ~complete_d. complete_d is a register that resets to 0.
- Reset state (the cycle after reset is sampled high): state=IDLE, k=0, complete_d=0. All outputs are 0: serial_s_out, serial_s_valid, serial_s_last, chan_idx, sample_idx, busy, frame_done.
- States:
  - IDLE:
    - On start_edge in cycle N: in cycle N+1, serial_s_out=word 0, chan_idx=0, sample_idx=0, serial_s_valid=1, busy=1; state goes to STREAM.
    - Latency from edge to first valid word is 1 cycle.
    - Without start_edge, all outputs stay at reset values.
  - STREAM:
    - valid&~ready: serial_s_out, chan_idx, sample_idx, serial_s_last and valid hold unchanged.
    - valid&ready with k<TOTAL-1: next cycle presents word k+1 with updated tags; valid stays 1, giving one word per cycle with ready tied high.
    - sample_idx wraps SAMPLES-1 -> 0 as chan_idx increments.
    - serial_s_last=1 exactly while k=TOTAL-1.
    - valid&ready with k=TOTAL-1: next cycle serial_s_valid=0, serial_s_last=0, busy=0, frame_done=1; state goes to DONE.
  - DONE:
    - One cycle only; frame_done drops next cycle and state returns to IDLE.
    - k, chan_idx and sample_idx clear to 0.
- Output register contents:
  - All outputs are registered.
  - serial_s_out is loaded from the s_est slice indexed by the next k; the slice is a combinational mux on the input bus.
  - No internal copy of the frame is kept.
- Retrigger rules:
  - start_edge during STREAM or DONE is ignored; complete_d still tracks the input.
  - sica_complete held high after a frame does not restart the stream; it must fall and rise again.
- Reset mid-stream:
  - Outputs return to reset values in the cycle after reset. The partial frame is abandoned with no frame_done and no last.
  - complete_d=0 after reset, so if sica_complete is still high when reset releases, a new frame starts from word 0 (edge seen against 0).
- Data is passed through bit-exact; there is no arithmetic on data words.

Test Plan:
- Reset values and idle:
  - Stimulus: DIM=2, SAMPLES=4, LOGM=2; word k = 100+k; assert reset 3 cycles.
  - Required: all outputs 0; no valid while sica_complete=0.
- Full frame, no backpressure:
  - Stimulus: sica_complete rises at cycle N; ready=1.
  - Required:
    - valid in cycles N+1..N+8 with data 100..107.
    - (chan_idx, sample_idx) = (0,0)..(0,3), (1,0)..(1,3).
    - last only on 107; frame_done at N+9; busy low at N+9.
- Backpressure:
  - Stimulus: ready low on words 2 and 5 for 3 cycles each.
  - Required: data/tags hold stable while stalled; 8 accepted words 100..107 in order, no drops or duplicates; frame lasts 14 cycles.
- No spurious retrigger:
  - Stimulus: sica_complete held high 40 cycles; also pulse it low then high mid-stream.
  - Required: exactly one frame of 8 words and one frame_done.
  - After the frame, a fresh low->high edge starts a second identical frame.
- Reset mid-stream:
  - Stimulus: assert reset after word 3 is accepted while sica_complete stays high.
  - Required: valid=0 the next cycle; no frame_done.
  - After reset releases, a full frame restarts from word 100 with tags (0,0).
